// File: rtl/rtc_spi_pkg.sv
// Shared definitions for the RTC SPI slave: FSM state encoding, byte width,
// frame length and the frame byte layout.
// Optional feature macro: RTC_SPI_CHECKSUM_EN appends a fourth byte to the frame.
// That byte is hours ^ minutes ^ seconds.
package rtc_spi_pkg;

  localparam int unsigned BYTE_W = 8;

`ifdef RTC_SPI_CHECKSUM_EN
  localparam int unsigned NBYTES = 4;
`else
  localparam int unsigned NBYTES = 3;
`endif

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  // Byte positions within a frame
  localparam logic [2:0] ByteHours   = 3'd0;
  localparam logic [2:0] ByteMinutes = 3'd1;
  localparam logic [2:0] ByteSeconds = 3'd2;
`ifdef RTC_SPI_CHECKSUM_EN
  localparam logic [2:0] ByteCheck   = 3'd3;
`endif
  localparam logic [2:0] LastIdx     = 3'(NBYTES - 1);

  // Frame byte at position idx; positions past the frame read as 0 (overrun).
  // The snapshot is packed as {hours, minutes, seconds}.
  function automatic logic [BYTE_W-1:0] frame_byte(input logic [2:0]          idx,
                                                   input logic [3*BYTE_W-1:0] snap);
    logic [BYTE_W-1:0] b;
    b = '0;
    case (idx)
      ByteHours:   b = snap[3*BYTE_W-1:2*BYTE_W];
      ByteMinutes: b = snap[2*BYTE_W-1:BYTE_W];
      ByteSeconds: b = snap[BYTE_W-1:0];
`ifdef RTC_SPI_CHECKSUM_EN
      ByteCheck:   b = snap[3*BYTE_W-1:2*BYTE_W] ^ snap[2*BYTE_W-1:BYTE_W] ^ snap[BYTE_W-1:0];
`endif
      default:     b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall detection
// on the synchronised value.
// Ports:
//   clk_i  - system clock
//   rst_i  - synchronous active-high reset; all flops load RstVal
//   pin_i  - asynchronous pin
//   sync_o - synchronised pin value
//   rise_o - one-cycle pulse on a synchronised 0->1 transition
//   fall_o - one-cycle pulse on a synchronised 1->0 transition
module spi_pin_sync #(
  parameter int unsigned SyncStages = 2,
  parameter logic        RstVal     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SyncStages{RstVal}};
      prev_q <= RstVal;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], pin_i};
      prev_q <= sync_q[SyncStages-1];
    end
  end

  assign sync_o = sync_q[SyncStages-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/rtc_spi_slave.sv
// SPI slave (mode 0, MSB first) serving an RTC time snapshot to the MSP430 master.
// The frame is hours, minutes, seconds, plus a checksum byte when RTC_SPI_CHECKSUM_EN
// is defined. Pins are oversampled on clk, which must run at least 8x spi_sclk.
// Ports:
//   clk, reset               - system clock, synchronous active-high reset
//   seconds/minutes/hours    - RTC time, snapshotted when the frame starts
//   spi_sclk/cs_n/mosi       - SPI inputs from the master (asynchronous)
//   spi_miso, spi_miso_oe    - SPI data out and its output enable
//   rx_byte, rx_valid        - last complete MOSI byte and its update pulse
//   frame_done               - pulse when a complete frame ends with cs_n rising
//   data_rdy                 - level interrupt: seconds changed since the last frame start
module rtc_spi_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seconds,
  input  logic [7:0] minutes,
  input  logic [7:0] hours,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_done,
  output logic       data_rdy
);
  import rtc_spi_pkg::*;

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;

  spi_pin_sync #(.SyncStages(SYNC_STAGES), .RstVal(1'b0)) u_sclk_sync (
    .clk_i  (clk),
    .rst_i  (reset),
    .pin_i  (spi_sclk),
    .sync_o (sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_pin_sync #(.SyncStages(SYNC_STAGES), .RstVal(1'b1)) u_cs_sync (
    .clk_i  (clk),
    .rst_i  (reset),
    .pin_i  (spi_cs_n),
    .sync_o (cs_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // MOSI only needs the same delay as sclk so it lines up with the detected edge.
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   mosi_s;

  always_ff @(posedge clk) begin
    if (reset) mosi_sync_q <= '0;
    else       mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  state_e              state_q;
  logic [3*BYTE_W-1:0] snap_q;
  logic [BYTE_W-1:0]   tx_sr_q;
  logic [BYTE_W-2:0]   rx_sr_q;
  logic [BYTE_W-1:0]   rx_next;
  logic [2:0]          bit_cnt_q;
  logic [2:0]          byte_idx_q;
  logic                miso_q, oe_q, rx_valid_q, frame_done_q, data_rdy_q;
  logic [BYTE_W-1:0]   rx_byte_q, sec_prev_q;

  assign rx_next = {rx_sr_q, mosi_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      snap_q       <= '0;
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      bit_cnt_q    <= '0;
      byte_idx_q   <= '0;
      miso_q       <= 1'b0;
      oe_q         <= 1'b0;
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      data_rdy_q   <= 1'b0;
      // Track the live input so leaving reset does not look like a seconds change.
      sec_prev_q   <= seconds;
    end else begin
      rx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      oe_q         <= ~cs_s;
      sec_prev_q   <= seconds;

      // Set has priority over the clear done by LOAD.
      if (seconds != sec_prev_q)  data_rdy_q <= 1'b1;
      else if (state_q == StLoad) data_rdy_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          miso_q <= 1'b0;
          if (cs_fall) state_q <= StLoad;
        end
        StLoad: begin
          if (cs_rise) begin
            miso_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            snap_q     <= {hours, minutes, seconds};
            miso_q     <= hours[7];
            tx_sr_q    <= {hours[6:0], 1'b0};
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            state_q    <= StShift;
          end
        end
        StShift, StDone: begin
          if (cs_rise) begin
            // Only a completed frame reports done; a partial rx byte is dropped.
            frame_done_q <= (state_q == StDone);
            miso_q       <= 1'b0;
            state_q      <= StIdle;
          end else if (sclk_rise) begin
            rx_sr_q   <= rx_next[BYTE_W-2:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_byte_q  <= rx_next;
              rx_valid_q <= 1'b1;
              if (state_q == StShift) begin
                byte_idx_q <= byte_idx_q + 3'd1;
                tx_sr_q    <= frame_byte(byte_idx_q + 3'd1, snap_q);
                if (byte_idx_q == LastIdx) state_q <= StDone;
              end else begin
                tx_sr_q <= '0;
              end
            end
          end else if (sclk_fall) begin
            miso_q  <= tx_sr_q[BYTE_W-1];
            tx_sr_q <= {tx_sr_q[BYTE_W-2:0], 1'b0};
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign rx_byte     = rx_byte_q;
  assign rx_valid    = rx_valid_q;
  assign frame_done  = frame_done_q;
  assign data_rdy    = data_rdy_q;

endmodule

// File: tb/tb_rtc_spi_slave.sv
module tb_rtc_spi_slave;

`ifdef RTC_SPI_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  typedef struct packed {
    logic [7:0] rx;
    logic [7:0] tx;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] seconds, minutes, hours;
  logic       spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe, rx_valid, frame_done, data_rdy;
  logic [7:0] rx_byte;

  int         checks = 0;
  int         failures = 0;
  int         fd_seen = 0;
  logic [7:0] miso_cap = '0;
  exp_t       sb[$];

  rtc_spi_slave #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .seconds     (seconds),
    .minutes     (minutes),
    .hours       (hours),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .frame_done  (frame_done),
    .data_rdy    (data_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected MISO byte i for the current time inputs.
  function automatic logic [7:0] exp_byte(input int i);
    case (i)
      0: return hours;
      1: return minutes;
      2: return seconds;
      3: return (NB == 4) ? (hours ^ minutes ^ seconds) : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  // One mode-0 bit: data set while sclk low, MISO captured at the rising edge.
  task automatic spi_bit(input logic b);
    spi_mosi = b;
    wclk(8);
    spi_sclk = 1'b1;
    miso_cap = {miso_cap[6:0], spi_miso};
    wclk(8);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_frame(input int nbits, input logic [31:0] mo, input int chg_bit,
                           input logic [7:0] chg_val, input int exp_fd);
    int fd0;
    fd0 = fd_seen;
    for (int i = 0; i < nbits / 8; i++) sb.push_back({mo[31-8*i -: 8], exp_byte(i)});
    spi_cs_n = 1'b0;
    wclk(6);
    chk("miso_oe_active", {31'd0, spi_miso_oe}, 32'd1);
    for (int b = 0; b < nbits; b++) begin
      spi_bit(mo[31-b]);
      if (b == chg_bit) seconds = chg_val;
    end
    wclk(8);
    spi_cs_n = 1'b1;
    wclk(8);
    chk("frame_done_count", fd_seen - fd0, exp_fd);
    chk("idle_oe_miso", {30'd0, spi_miso_oe, spi_miso}, 32'd0);
  endtask

  // Scoreboard monitor: one entry per completed byte.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected: got rx_byte %0h expected no rx_valid", rx_byte);
        end else begin
          e = sb.pop_front();
          chk("rx_byte", {24'd0, rx_byte}, {24'd0, e.rx});
          chk("miso_byte", {24'd0, miso_cap}, {24'd0, e.tx});
        end
      end
      if (frame_done) fd_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hours   = 8'h12;
    minutes = 8'h34;
    seconds = 8'h56;

    // 1: reset, pins idle
    reset = 1'b1;
    wclk(3);
    chk("rst_miso", {31'd0, spi_miso}, 32'd0);
    chk("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    chk("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_data_rdy", {31'd0, data_rdy}, 32'd0);
    reset = 1'b0;
    wclk(4);
    chk("post_rst_data_rdy", {31'd0, data_rdy}, 32'd0);

    // 2: 24-bit read
    spi_frame(24, 32'hA500FF00, -1, 8'h00, (NB == 3) ? 1 : 0);

    // 3: 32-bit read (checksum byte or overrun zeros)
    spi_frame(32, 32'h3CC35A0F, -1, 8'h00, 1);

    // 4: seconds change mid-frame does not corrupt the snapshot
    spi_frame(24, 32'h0F1E2D00, 10, 8'h57, (NB == 3) ? 1 : 0);
    chk("data_rdy_set", {31'd0, data_rdy}, 32'd1);

    // 5: aborted after 12 sclk, then a full frame from hours
    spi_frame(12, 32'hC3A00000, -1, 8'h00, 0);
    chk("data_rdy_cleared", {31'd0, data_rdy}, 32'd0);
    spi_frame(32, 32'h01020304, -1, 8'h00, 1);

    // 6: reset mid-SHIFT
    spi_cs_n = 1'b0;
    wclk(6);
    for (int b = 0; b < 5; b++) spi_bit(1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_miso", {31'd0, spi_miso}, 32'd0);
    chk("midrst_oe", {31'd0, spi_miso_oe}, 32'd0);
    spi_cs_n = 1'b1;
    wclk(3);
    reset = 1'b0;
    wclk(4);
    spi_frame(32, 32'h89ABCDEF, -1, 8'h00, 1);

    wclk(20);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
